// File: rtl/sobol_sched.sv
// sobol_sched -- round-robin scheduler sharing one Sobol->ICDF Gaussian
// sample pipeline between NUM_REQ requesters.
//
// A winning requester gets a one-cycle gnt pulse. gen_start is then driven
// once per sample for the whole burst. A PIPE_LAT-deep tag shift register
// runs alongside the generator, so each returning sample is tagged with
// its owner and a last flag. The sample is steered out through
// out_data/out_valid/out_id/out_last. After the last sample, a done pulse
// goes to the owner.
//
// Build option: define SOBOL_SCHED_PRIO_EN for fixed priority (lowest index
// wins). The default build is round-robin.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req[NUM_REQ]     request levels (sampled only while idle)
//   req_len          packed burst lengths, field i = [i*BURST_W +: BURST_W],
//                    0 means 2^BURST_W
//   gnt              one-hot, one-cycle grant pulse
//   busy             burst issuing or draining
//   gen_start        per-sample advance to the generator
//   gen_icdf         generator sample, valid PIPE_LAT cycles after gen_start
//   out_data/out_valid/out_id/out_last  registered, steered sample stream
//   done             one-cycle completion pulse to the burst owner

module sobol_sched_len_dec #(
  parameter int BURST_W = 8
) (
  input  logic [BURST_W-1:0] len,
  output logic [BURST_W:0]   dec
);
  // A zero field encodes the maximum burst of 2^BURST_W samples.
  assign dec = (len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, len};
endmodule

module sobol_sched #(
  parameter int NUM_REQ  = 4,
  parameter int BURST_W  = 8,
  parameter int PIPE_LAT = 3,
  parameter int DATA_W   = 16,
  localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BURST_W-1:0] req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       gen_start,
  input  logic [DATA_W-1:0]          gen_icdf,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_last,
  output logic [NUM_REQ-1:0]         done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

  localparam logic [BURST_W:0]   CNT_ONE = 1;
  localparam logic [NUM_REQ-1:0] REQ_ONE = 1;

  state_t state_q, state_d;

  logic [BURST_W:0] cnt_q;
  logic [ID_W-1:0]  owner_q;
  logic             win_any;
  logic [ID_W-1:0]  win_id;
  logic             issue_last;

  logic [PIPE_LAT:1] vld_pipe;
  tag_t              tag_pipe [1:PIPE_LAT];
  logic              push_vld;
  tag_t              push_tag;

  // ---------------------------------------------------------------------
  // Per-requester length decode
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0][BURST_W:0] len_dec;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    sobol_sched_len_dec #(.BURST_W(BURST_W)) u_dec (
      .len (req_len[i*BURST_W +: BURST_W]),
      .dec (len_dec[i])
    );
  end

  // ---------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------
`ifdef SOBOL_SCHED_PRIO_EN
  // Fixed priority: scan downward so the lowest set index is the last write.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        win_any = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q;

  // Round-robin: the first set bit above the last winner, with wrap. The
  // last winner is checked last, so a held request yields to the others.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  assign issue_last = (cnt_q == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any)    state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      // out_last is registered, so leaving here puts done and the next
      // arbitration in the cycle after the final sample.
      DRAIN:   if (out_last)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign gen_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Grant / counter / done
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      done    <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
`ifndef SOBOL_SCHED_PRIO_EN
      ptr_q   <= ID_W'(NUM_REQ-1);
`endif
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state_q)
        IDLE: begin
          if (win_any) begin
            gnt     <= REQ_ONE << win_id;
            cnt_q   <= len_dec[win_id];
            owner_q <= win_id;
`ifndef SOBOL_SCHED_PRIO_EN
            ptr_q   <= win_id;
`endif
          end
        end
        ISSUE:   cnt_q <= cnt_q - CNT_ONE;
        DRAIN:   if (out_last) done <= REQ_ONE << out_id;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipe: stage k holds the tag of the gen_start issued k cycles ago.
  // Stage PIPE_LAT therefore lines up with the sample now on gen_icdf.
  // ---------------------------------------------------------------------
  assign push_vld = (state_q == ISSUE);
  assign push_tag = '{id: owner_q, last: issue_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= PIPE_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      vld_pipe[1] <= push_vld;
      tag_pipe[1] <= push_tag;
      for (int k = 2; k <= PIPE_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register: data and id only load on a valid sample, so both hold
  // between bursts.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      out_valid <= vld_pipe[PIPE_LAT];
      out_last  <= vld_pipe[PIPE_LAT] & tag_pipe[PIPE_LAT].last;
      if (vld_pipe[PIPE_LAT]) begin
        out_data <= gen_icdf;
        out_id   <= tag_pipe[PIPE_LAT].id;
      end
    end
  end

endmodule

// File: tb/tb_sobol_sched.sv
// Bench for sobol_sched. A timeline model predicts every output per cycle:
// when a burst of length L is granted at cycle g, it fills expectation
// arrays for gnt, gen_start, busy, out_valid/out_last/out_id and done.
// out_data is predicted from a history of the driven gen_icdf values.
module tb_sobol_sched;
  localparam int NR   = 4;
  localparam int BW   = 8;
  localparam int LAT  = 3;
  localparam int DW   = 16;
  localparam int IW   = 2;
  localparam int NCYC = 8192;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*BW-1:0]  req_len;
  logic [NR-1:0]     gnt;
  logic              busy;
  logic              gen_start;
  logic [DW-1:0]     gen_icdf;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [IW-1:0]     out_id;
  logic              out_last;
  logic [NR-1:0]     done;

  always #5 clk = ~clk;

  sobol_sched #(.NUM_REQ(NR), .BURST_W(BW), .PIPE_LAT(LAT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
    .busy(busy), .gen_start(gen_start), .gen_icdf(gen_icdf),
    .out_data(out_data), .out_valid(out_valid), .out_id(out_id),
    .out_last(out_last), .done(done)
  );

  logic [NR-1:0] e_gnt  [NCYC];
  logic [NR-1:0] e_done [NCYC];
  bit            e_gs   [NCYC];
  bit            e_busy [NCYC];
  bit            e_ov   [NCYC];
  bit            e_ol   [NCYC];
  int            e_id   [NCYC];
  logic [DW-1:0] gen_hist [NCYC];
  bit            rst_hist [NCYC];

  int cyc = 0, free_at = 0, ptr = NR-1;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] exp_data = '0;
  int exp_id = 0;
  bit use_cnt = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic int pick(input logic [NR-1:0] r);
    int w;
    w = -1;
`ifdef SOBOL_SCHED_PRIO_EN
    for (int i = NR-1; i >= 0; i--) if (r[i]) w = i;
`else
    for (int i = NR; i >= 1; i--) if (r[(ptr+i)%NR]) w = (ptr+i)%NR;
`endif
    return w;
  endfunction

  // Decide what happens at the edge that ends cycle cyc.
  task automatic model_step();
    int c, w, len, g;
    c = cyc;
    rst_hist[c] = rst;
    gen_hist[c] = gen_icdf;
    if (rst) begin
      for (int k = c+1; k < NCYC && k <= c+LAT+(1<<BW)+4; k++) begin
        e_gnt[k] = '0; e_done[k] = '0; e_gs[k] = 0; e_busy[k] = 0;
        e_ov[k] = 0; e_ol[k] = 0; e_id[k] = 0;
      end
      ptr = NR-1;
      free_at = c+1;
    end else if (c >= free_at && req != '0) begin
      w   = pick(req);
      len = int'(req_len[w*BW +: BW]);
      if (len == 0) len = 1 << BW;
      g = c+1;
      if (g+LAT+len+1 < NCYC) begin
        e_gnt[g] = NR'(1) << w;
        for (int k = 0; k < len; k++) begin
          e_gs[g+k] = 1;
          e_ov[g+LAT+1+k] = 1;
          e_id[g+LAT+1+k] = w;
        end
        for (int k = g; k <= g+LAT+len; k++) e_busy[k] = 1;
        e_ol[g+LAT+len] = 1;
        e_done[g+LAT+len+1] = NR'(1) << w;
      end
      ptr = w;
      free_at = g+LAT+len+1;
    end
  endtask

  task automatic check_cycle();
    int c;
    c = cyc;
    if (rst_hist[c-1]) begin
      exp_data = '0;
      exp_id = 0;
    end else if (e_ov[c]) begin
      exp_data = gen_hist[c-1];
      exp_id = e_id[c];
    end
    chk("gnt",       32'(gnt),       32'(e_gnt[c]));
    chk("busy",      32'(busy),      32'(e_busy[c]));
    chk("gen_start", 32'(gen_start), 32'(e_gs[c]));
    chk("out_valid", 32'(out_valid), 32'(e_ov[c]));
    chk("out_last",  32'(out_last),  32'(e_ol[c]));
    chk("done",      32'(done),      32'(e_done[c]));
    chk("out_id",    32'(out_id),    32'(exp_id));
    chk("out_data",  32'(out_data),  32'(exp_data));
  endtask

  task automatic tick(input bit r, input logic [NR-1:0] rq, input logic [NR*BW-1:0] ln);
    rst      = r;
    req      = rq;
    req_len  = ln;
    gen_icdf = use_cnt ? DW'(cyc) : DW'($urandom);
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
  endtask

  function automatic logic [NR*BW-1:0] lens_all(input logic [BW-1:0] v);
    logic [NR*BW-1:0] l;
    for (int i = 0; i < NR; i++) l[i*BW +: BW] = v;
    return l;
  endfunction

  initial begin
    logic [NR*BW-1:0] ln;
    logic [NR-1:0] rq;
    for (int k = 0; k < NCYC; k++) begin
      e_gnt[k] = '0; e_done[k] = '0; e_gs[k] = 0; e_busy[k] = 0;
      e_ov[k] = 0; e_ol[k] = 0; e_id[k] = 0; gen_hist[k] = '0; rst_hist[k] = 0;
    end

    // Reset
    for (int i = 0; i < 3; i++) tick(1'b1, '0, '0);
    idle(2);

    // Single burst: requester 2, length 4
    ln = '0; ln[2*BW +: BW] = BW'(4);
    tick(1'b0, 4'b0100, ln);
    idle(15);

    // Round-robin with all requesters held, length 1
    for (int i = 0; i < 40; i++) tick(1'b0, 4'b1111, lens_all(BW'(1)));
    idle(20);

    // Length 0 -> 2^BURST_W samples
    ln = '0;
    tick(1'b0, 4'b0010, ln);
    idle((1 << BW) + 20);

    // Reset during the 5th gen_start cycle of a length-10 burst
    ln = '0; ln[3*BW +: BW] = BW'(10);
    tick(1'b0, 4'b1000, ln);
    idle(4);
    tick(1'b1, '0, '0);
    for (int i = 0; i < 30; i++) tick(1'b0, 4'b1111, lens_all(BW'(2)));
    idle(20);

    // Fixed pattern 1010 held
    for (int i = 0; i < 60; i++) tick(1'b0, 4'b1010, lens_all(BW'(3)));
    idle(20);

    // Randomized traffic with random data and rare resets
    use_cnt = 1'b0;
    while (cyc < 6900) begin
      rq = NR'($urandom_range(0, (1 << NR) - 1));
      for (int i = 0; i < NR; i++)
        ln[i*BW +: BW] = ($urandom_range(0, 24) == 0) ? '0 : BW'($urandom_range(1, 6));
      tick($urandom_range(0, 499) == 0, rq, ln);
    end
    idle((1 << BW) + 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sobol_sched.md
Name: sobol_sched

Overview:
- Round-robin scheduler that shares one Sobol-to-ICDF Gaussian sample pipeline between NUM_REQ requesters.
- A requester asks for a burst of samples. The scheduler grants one requester at a time and drives the pipeline's start input once per sample.
- Samples returning from the fixed-latency pipeline carry a tag (requester id and last flag). Each sample is steered to its owner.
- Sits between the Monte-Carlo consumer blocks and the Sobol generator top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_W, 8, width of each burst-length field.
- PIPE_LAT, 3, cycles from gen_start high to the matching gen_icdf sample being valid (>=1).
- DATA_W, 16, sample width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_len  in  NUM_REQ*BURST_W  burst length per requester; field i = bits [i*BURST_W +: BURST_W]; value 0 means 2^BURST_W.
- gnt  out  NUM_REQ  one-hot grant pulse, 1 cycle.
- busy  out  1  high while a burst is issuing or draining.
- gen_start  out  1  one-cycle-per-sample advance to the generator.
- gen_icdf  in  DATA_W  sample from the generator, valid PIPE_LAT cycles after the matching gen_start.
- out_data  out  DATA_W  registered copy of gen_icdf.
- out_valid  out  1  out_data belongs to the granted burst.
- out_id  out  clog2(NUM_REQ) (min 1)  owner of out_data.
- out_last  out  1  final sample of the burst.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, busy=0, gen_start=0, out_valid=0, out_last=0, done=0, out_data=0, out_id=0, remaining counter=0, tag pipe cleared, rr pointer=NUM_REQ-1 (so requester 0 wins first).
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, any req high at edge t:
  - Winner = first set bit searching upward from pointer+1, with wrap.
  - Registered at t+1: gnt[winner]=1 for exactly one cycle, pointer=winner, counter=decoded length, state=ISSUE.
  - With no req, stay in IDLE.
- ISSUE:
  - gen_start=1 every cycle.
  - Push tag {valid=1, id, last=(counter==1)} into the PIPE_LAT-deep tag shift register.
  - Decrement counter; on counter==1, go to DRAIN next cycle.
  - gen_start therefore stays high for exactly L cycles, t+1..t+L.
- Tag pipe: stage PIPE_LAT aligns with gen_icdf.
  - out_data, out_valid, out_id and out_last are registered from that stage.
  - First out_valid is at t+1+PIPE_LAT+1; out_last is on the L-th valid sample.
  - Both are one cycle after gen_icdf is valid; out_data is a register stage.
- DRAIN:
  - gen_start=0; empty tags are shifted in.
  - The cycle after out_last is high: done[id]=1 for one cycle, busy=0, state=IDLE.
  - Arbitration resumes in that cycle.
- busy is 1 from the gnt cycle through the out_last cycle inclusive.
- req is sampled only in IDLE. A requester may hold or drop req after gnt; holding it requests another burst, which is served after the other pending requesters in round-robin order.
- req_len is sampled only in the winning IDLE cycle; later changes are ignored.
- Length 0 decodes to 2^BURST_W samples. The counter is BURST_W+1 bits wide.
- Simultaneous requests: at most one gnt bit per cycle. All others wait with no loss.
- rst mid-burst: all state and outputs return to reset values the next cycle. Samples still in the generator are discarded (tags cleared, so out_valid=0), and no done is issued.
- out_data holds its last value when out_valid=0.

Optional Feature:
- Macro SOBOL_SCHED_PRIO_EN.
  - Defined: fixed priority; lowest index wins; pointer unused.
  - Undefined (default): round-robin as above.

Test Plan:
- Single burst, PIPE_LAT=3: req[2]=1 with len 4 at cycle 0 → gnt=4'b0100 at 1; gen_start high cycles 1-4; out_valid cycles 5-8 with out_id=2; out_last at 8; done[2] at 9; busy high 1-8.
- Round-robin: req=4'b1111 held, all len 1 → grants in order 0,1,2,3,0; no two gnt bits set together; every burst yields exactly one out_valid.
- Length wrap: len=0 with BURST_W=8 → exactly 256 gen_start cycles and 256 out_valid; out_last only on the 256th.
- Reset mid-burst: len 10, rst asserted at the 5th gen_start cycle → next cycle all outputs 0; no out_valid or done for the aborted burst; next request is granted to requester 0 first.
- Data steering: gen_icdf driven with a cycle counter → out_data equals gen_icdf from the previous cycle whenever out_valid=1; sample k of the burst equals the value present PIPE_LAT cycles after the k-th gen_start.
- With SOBOL_SCHED_PRIO_EN and req=4'b1010 held → requester 1 wins every arbitration; requester 3 is never granted while req[1] stays high.
